// File: rtl/mipi_tx_pkg.sv
// Shared defaults, configuration FSM encoding and delay clamp for the MIPI TX lane deskew.
package mipi_tx_pkg;
    localparam int LANES_DEF   = 4;
    localparam int DW_DEF      = 8;
    localparam int MAX_DLY_DEF = 7;
    localparam int DLY_W_DEF   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        APPLY = 2'd2
    } cfg_state_e;

    function automatic int unsigned clamp_dly(input int unsigned d, input int unsigned max_d);
        return (d > max_d) ? max_d : d;
    endfunction
endpackage

// File: rtl/mipi_tx_lane_deskew_if.sv
// Lane data and delay-configuration bundle between lane distribution and the deskew block.
interface mipi_tx_lane_deskew_if
    import mipi_tx_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int DW    = DW_DEF,
    parameter int DLY_W = DLY_W_DEF
);
    logic [LANES-1:0]            i_valid;
    logic [LANES-1:0][DW-1:0]    i_data;
    logic [LANES-1:0][DLY_W-1:0] cfg_dly;
    logic                        cfg_load;
    logic                        cfg_ack;
    logic                        cfg_pending;
    logic [LANES-1:0]            o_valid;
    logic [LANES-1:0][DW-1:0]    o_data;
    logic                        o_busy;

    modport master (
        output i_valid, i_data, cfg_dly, cfg_load,
        input  cfg_ack, cfg_pending, o_valid, o_data, o_busy
    );
    modport slave (
        input  i_valid, i_data, cfg_dly, cfg_load,
        output cfg_ack, cfg_pending, o_valid, o_data, o_busy
    );
endinterface

// File: rtl/mipi_tx_lane_dly.sv
// One lane: MAX_DLY+1 stage {valid,data} shift register, delay tap mux and output register.
module mipi_tx_lane_dly
    import mipi_tx_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int MAX_DLY = MAX_DLY_DEF,
    parameter int DLY_W   = DLY_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [DW-1:0]    in_data,
    input  logic [DLY_W-1:0] dly,
    output logic             out_valid,
    output logic [DW-1:0]    out_data,
    output logic             busy
);
    logic [MAX_DLY:0]         vld_pipe;
    logic [MAX_DLY:0][DW-1:0] data_pipe;
    logic                     tap_vld;
    logic [DW-1:0]            tap_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe  <= '0;
            data_pipe <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            vld_pipe  <= {vld_pipe[MAX_DLY-1:0], in_valid};
            data_pipe <= {data_pipe[MAX_DLY-1:0], in_data};
            out_valid <= tap_vld;
            out_data  <= tap_data;
        end
    end

    // dly is clamped upstream, so exactly one tap matches
    always_comb begin
        tap_vld  = 1'b0;
        tap_data = '0;
        for (int n = 0; n <= MAX_DLY; n++) begin
            if (dly == DLY_W'(n)) begin
                tap_vld  = vld_pipe[n];
                tap_data = data_pipe[n];
            end
        end
    end

    assign busy = |vld_pipe;
endmodule

// File: rtl/mipi_tx_lane_deskew.sv
// Per-lane programmable TX pre-skew; delay changes are held pending until every lane drains.
module mipi_tx_lane_deskew
    import mipi_tx_pkg::*;
#(
    parameter int LANES   = LANES_DEF,
    parameter int DW      = DW_DEF,
    parameter int MAX_DLY = MAX_DLY_DEF,
    parameter int DLY_W   = DLY_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    mipi_tx_lane_deskew_if.slave bus
);
    cfg_state_e                  state, state_nxt;
    logic [LANES-1:0][DLY_W-1:0] act_dly, pend_dly, cfg_clamped;
    logic [LANES-1:0]            lane_busy, lane_ovld;
    logic [LANES-1:0][DW-1:0]    lane_odata;
    logic                        idle_ok, ack;

    always_comb begin
        cfg_clamped = '0;
        for (int k = 0; k < LANES; k++)
            cfg_clamped[k] = DLY_W'(clamp_dly(32'(bus.cfg_dly[k]), 32'(MAX_DLY)));
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        mipi_tx_lane_dly #(.DW(DW), .MAX_DLY(MAX_DLY), .DLY_W(DLY_W)) u_lane (
            .clk      (clk),
            .rst      (rst),
            .in_valid (bus.i_valid[k]),
            .in_data  (bus.i_data[k]),
            .dly      (act_dly[k]),
            .out_valid(lane_ovld[k]),
            .out_data (lane_odata[k]),
            .busy     (lane_busy[k])
        );
    end

    // nothing in flight and nothing arriving: safe to swap taps
    assign idle_ok = !(|lane_busy) && !(|bus.i_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            act_dly  <= '0;
            pend_dly <= '0;
        end else begin
            state <= state_nxt;
            if (bus.cfg_load)   pend_dly <= cfg_clamped;
            if (state == APPLY) act_dly  <= pend_dly;
        end
    end

    always_comb begin
        state_nxt = state;
        ack       = 1'b0;
        case (state)
            IDLE:    if (bus.cfg_load) state_nxt = PEND;
            PEND:    if (!bus.cfg_load && idle_ok) state_nxt = APPLY;
            APPLY: begin
                ack       = 1'b1;
                state_nxt = bus.cfg_load ? PEND : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.cfg_ack     = ack;
    assign bus.cfg_pending = (state == PEND) || (state == APPLY);
    assign bus.o_valid     = lane_ovld;
    assign bus.o_data      = lane_odata;
    assign bus.o_busy      = |lane_busy;
endmodule

// File: tb/tb_mipi_tx_lane_deskew.sv
// Directed bench for mipi_tx_lane_deskew with a per-lane expected-byte scoreboard.
module tb_mipi_tx_lane_deskew;
    localparam int LANES   = 4;
    localparam int DW      = 8;
    localparam int MAX_DLY = 7;
    localparam int DLY_W   = 4;

    typedef struct {
        int            due;
        logic [DW-1:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vec = 0;
    int   errs = 0;
    int   cyc = 0;
    int   mdly [LANES];
    exp_t sb [LANES][$];

    mipi_tx_lane_deskew_if #(.LANES(LANES), .DW(DW), .DLY_W(DLY_W)) bus ();

    mipi_tx_lane_deskew #(.LANES(LANES), .DW(DW), .MAX_DLY(MAX_DLY), .DLY_W(DLY_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic sb_check();
        exp_t e;
        for (int k = 0; k < LANES; k++) begin
            if (sb[k].size() > 0 && sb[k][0].due == cyc) begin
                e = sb[k].pop_front();
                chk($sformatf("vld%0d", k), 32'(bus.o_valid[k]), 32'd1);
                chk($sformatf("data%0d", k), 32'(bus.o_data[k]), 32'(e.d));
            end else begin
                chk($sformatf("idle%0d", k), 32'(bus.o_valid[k]), 32'd0);
            end
        end
    endtask

    // inputs are changed at the falling edge; outputs checked there too
    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        sb_check();
    endtask

    task automatic clr_in();
        bus.i_valid  = '0;
        bus.i_data   = '0;
        bus.cfg_load = 1'b0;
    endtask

    task automatic idle(input int n);
        clr_in();
        for (int i = 0; i < n; i++) tick();
    endtask

    // byte sampled at the next edge (cyc+1) must leave at cyc+1+dly+1
    task automatic put(input int k, input logic [DW-1:0] d);
        bus.i_valid[k] = 1'b1;
        bus.i_data[k]  = d;
        sb[k].push_back('{due: cyc + 2 + mdly[k], d: d});
    endtask

    task automatic load_idle(input logic [LANES-1:0][DLY_W-1:0] cfg);
        bus.cfg_dly  = cfg;
        bus.cfg_load = 1'b1;
        tick();
        bus.cfg_load = 1'b0;
        chk("ld_ack_t", 32'(bus.cfg_ack), 32'd0);
        tick();
        chk("ld_ack_t1", 32'(bus.cfg_ack), 32'd1);
        chk("ld_pend_t1", 32'(bus.cfg_pending), 32'd1);
        tick();
        chk("ld_ack_t2", 32'(bus.cfg_ack), 32'd0);
        chk("ld_pend_t2", 32'(bus.cfg_pending), 32'd0);
    endtask

    initial begin
        int e_last, ack_at, ackcnt, left;
        clr_in();
        bus.cfg_dly = '0;
        for (int k = 0; k < LANES; k++) mdly[k] = 0;

        // reset state
        rst = 1'b1;
        tick();
        tick();
        chk("rst_ovld", 32'(bus.o_valid), 32'd0);
        chk("rst_odata", 32'(bus.o_data), 32'd0);
        chk("rst_ack", 32'(bus.cfg_ack), 32'd0);
        chk("rst_pend", 32'(bus.cfg_pending), 32'd0);
        chk("rst_busy", 32'(bus.o_busy), 32'd0);
        rst = 1'b0;

        // default delay 0: byte at cycle 10 out at cycle 11
        while (cyc < 9) tick();
        put(0, 8'hA5);
        tick();
        clr_in();
        chk("def_busy", 32'(bus.o_busy), 32'd1);
        idle(10);

        // per-lane skew {7,0,2,5} on lanes 3..0
        load_idle({4'd7, 4'd0, 4'd2, 4'd5});
        mdly[0] = 5; mdly[1] = 2; mdly[2] = 0; mdly[3] = 7;
        put(0, 8'h11); put(1, 8'h22); put(2, 8'h33); put(3, 8'h44);
        tick();
        idle(12);

        // deferred apply: delay 2 -> 4 requested mid-burst
        load_idle({LANES{4'd2}});
        for (int k = 0; k < LANES; k++) mdly[k] = 2;
        for (int i = 0; i < 20; i++) begin
            for (int k = 0; k < LANES; k++) put(k, 8'(i * 4 + k + 1));
            if (i == 5) begin
                bus.cfg_dly  = {LANES{4'd4}};
                bus.cfg_load = 1'b1;
            end
            tick();
            clr_in();
            if (i > 5) begin
                chk("dfr_pend_burst", 32'(bus.cfg_pending), 32'd1);
                chk("dfr_ack_burst", 32'(bus.cfg_ack), 32'd0);
            end
        end
        // last byte clears stage MAX_DLY at e_last+MAX_DLY+1, APPLY follows
        e_last = cyc;
        ack_at = e_last + MAX_DLY + 2;
        while (cyc < ack_at + 1) begin
            tick();
            if (cyc < ack_at) begin
                chk("dfr_ack_wait", 32'(bus.cfg_ack), 32'd0);
                chk("dfr_pend_wait", 32'(bus.cfg_pending), 32'd1);
            end else if (cyc == ack_at) begin
                chk("dfr_ack", 32'(bus.cfg_ack), 32'd1);
            end
            if (cyc == ack_at - 1) chk("dfr_busy0", 32'(bus.o_busy), 32'd0);
        end
        chk("dfr_pend_done", 32'(bus.cfg_pending), 32'd0);
        for (int k = 0; k < LANES; k++) mdly[k] = 4;
        for (int k = 0; k < LANES; k++) put(k, 8'hC0 + 8'(k));
        tick();
        idle(8);

        // overwrite while pending: 1 then 6, one ack, delay 6 everywhere
        ackcnt = 0;
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < LANES; k++) put(k, 8'h80 + 8'(i * 4 + k));
            if (i == 1) begin
                bus.cfg_dly  = {LANES{4'd1}};
                bus.cfg_load = 1'b1;
            end
            if (i == 3) begin
                bus.cfg_dly  = {LANES{4'd6}};
                bus.cfg_load = 1'b1;
            end
            tick();
            clr_in();
            ackcnt += int'(bus.cfg_ack);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            ackcnt += int'(bus.cfg_ack);
        end
        chk("ovw_ackcnt", 32'(ackcnt), 32'd1);
        for (int k = 0; k < LANES; k++) mdly[k] = 6;
        for (int k = 0; k < LANES; k++) put(k, 8'h60 + 8'(k));
        tick();
        idle(10);

        // clamp: 12 requested, MAX_DLY=7 -> latency 8
        load_idle({LANES{4'd12}});
        for (int k = 0; k < LANES; k++) mdly[k] = 7;
        for (int k = 0; k < LANES; k++) put(k, 8'hD0 + 8'(k));
        tick();
        idle(11);

        // reset while pending with bytes in flight
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < LANES; k++) put(k, 8'hE0 + 8'(i * 4 + k));
            if (i == 1) begin
                bus.cfg_dly  = {LANES{4'd3}};
                bus.cfg_load = 1'b1;
            end
            tick();
            clr_in();
        end
        tick();
        chk("rm_pend_pre", 32'(bus.cfg_pending), 32'd1);
        for (int k = 0; k < LANES; k++) sb[k].delete();
        rst = 1'b1;
        tick();
        chk("rm_ovld", 32'(bus.o_valid), 32'd0);
        chk("rm_pend", 32'(bus.cfg_pending), 32'd0);
        chk("rm_busy", 32'(bus.o_busy), 32'd0);
        rst = 1'b0;
        ackcnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            ackcnt += int'(bus.cfg_ack);
        end
        chk("rm_noack", 32'(ackcnt), 32'd0);
        for (int k = 0; k < LANES; k++) mdly[k] = 0;
        for (int k = 0; k < LANES; k++) put(k, 8'hF0 + 8'(k));
        tick();
        idle(4);

        left = 0;
        for (int k = 0; k < LANES; k++) left += sb[k].size();
        chk("sb_empty", 32'(left), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule

// File: doc/mipi_tx_lane_deskew.md
# mipi_tx_lane_deskew

Transmit-side per-lane byte delay line for the MIPI TX path. It pre-skews each HS data lane by a programmable number of byte-clock cycles before the serializer, so that board and package skew cancels at the far-end receiver. It sits between the packet/lane-distribution logic and the per-lane TX serializers, in the byte-clock domain. Delay settings are changed only when every lane's pipeline is empty, never in the middle of a packet.

## Interface
Parameters:
- LANES, 4: number of HS data lanes.
- DW, 8: bits per lane per byte-clock cycle.
- MAX_DLY, 7: largest delay per lane, in cycles.
- DLY_W, 3: width of one lane's delay field; must satisfy 2^DLY_W > MAX_DLY.

Ports:
- clk, input, 1: byte clock. This is the only clock.
- rst, input, 1: synchronous, active-high reset.
- i_valid, input, LANES: per-lane byte valid.
- i_data, input, LANES*DW: lane k occupies bits [k*DW +: DW].
- cfg_dly, input, LANES*DLY_W: requested delay for lane k, at [k*DLY_W +: DLY_W].
- cfg_load, input, 1: one-cycle pulse that captures cfg_dly.
- cfg_ack, output, 1: one-cycle pulse when the new delays become active.
- cfg_pending, output, 1: a captured configuration is waiting to be applied.
- o_valid, output, LANES: delayed per-lane valid.
- o_data, output, LANES*DW: delayed per-lane data.
- o_busy, output, 1: at least one valid byte is in flight in some lane.

## Operation
- Each lane has a MAX_DLY+1 stage shift register carrying {valid, data}.
  - Stage 0 loads {i_valid[k], i_data[k]} on every cycle.
  - Stage n loads stage n-1.
- Output register per lane: o_valid[k]/o_data[k] take stage act_dly[k] every cycle.
- act_dly[k] is the active delay. Total latency for lane k = act_dly[k] + 1 cycles.
- Lanes are independent. A valid byte is never dropped or duplicated while its delay setting stays unchanged.
- Values of cfg_dly above MAX_DLY are clamped to MAX_DLY when captured.
- o_busy is the OR of all stage valid bits across all lanes (registered stages only, not i_valid).
- Configuration FSM, states IDLE, PEND, APPLY:
  - IDLE: cfg_load=1 captures the clamped cfg_dly into pend_dly and moves to PEND.
  - PEND: cfg_load=1 overwrites pend_dly (the latest request wins) and stays in PEND. When o_busy=0 and i_valid=0 in the same cycle, move to APPLY.
  - APPLY (one cycle): act_dly <= pend_dly, cfg_ack=1, return to IDLE. If cfg_load=1 in this cycle, the new value is captured into pend_dly and the next state is PEND, not IDLE.
- cfg_pending = 1 in PEND and APPLY, 0 in IDLE.
- If i_valid rises while in PEND, the apply waits until the pipeline drains again. There is no timeout.

## Timing
- Reset: all stages cleared, act_dly = 0, pend_dly = 0, FSM = IDLE.
  - o_valid = 0, o_data = 0, cfg_ack = 0, cfg_pending = 0, o_busy = 0.
- Lane k: a byte presented at cycle t appears on o_data[k] at cycle t + act_dly[k] + 1.
- cfg_load at cycle t with the pipeline already idle:
  - cfg_pending=1 from t+1.
  - APPLY in cycle t+1, so cfg_ack=1 at t+1.
  - New latency applies to bytes entering from t+2.
- rst asserted mid-packet: all in-flight bytes are discarded and pend_dly is lost. No cfg_ack is issued.

## Structure
- Shared package mipi_tx_pkg:
  - defaults for LANES, DW, MAX_DLY, DLY_W;
  - the FSM state encoding (IDLE=2'd0, PEND=2'd1, APPLY=2'd2);
  - a clamp function for delay values.
- Sub-module mipi_tx_lane_dly: one lane containing the shift register, tap mux and output register, parameterized by DW and MAX_DLY. The top level instantiates LANES copies and owns the configuration FSM and o_busy.

## Test plan
- Reset default: after reset with cfg never loaded, drive lane0 valid with byte 0xA5 at cycle 10 -> o_data lane0 = 0xA5, o_valid[0]=1 at cycle 11; all other lanes keep o_valid=0.
- Per-lane skew: load cfg_dly = {3'd7, 3'd0, 3'd2, 3'd5} while idle, then drive 0x11/0x22/0x33/0x44 on lanes 0..3 at cycle t.
  - cfg_ack is seen one cycle after cfg_load.
  - Lane 0 outputs at t+6, lane 1 at t+3, lane 2 at t+1, lane 3 at t+8.
- Deferred apply: issue cfg_load mid-packet (a 20-byte burst, delay 2 -> 4) -> cfg_pending=1 and cfg_ack=0 until the burst drains. All 20 bytes come out with latency 3, with no gaps or duplicates. cfg_ack fires in the first cycle in which o_busy=0 and i_valid=0.
- Overwrite in PEND: load delay 1, then load delay 6 while busy -> exactly one cfg_ack, and the active delay on all lanes is 6.
- Clamp: with DLY_W=4 and MAX_DLY=7, load cfg_dly=4'd12 -> latency is 8 cycles.
- Reset mid-operation: assert rst in PEND with bytes in flight -> the next cycle shows o_valid=0, cfg_pending=0, o_busy=0; no cfg_ack follows; act_dly returns to 0.
